// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if
//   Bundles the CPU store, scanout, display-timing and framebuffer RAM signals
//   seen by vga_fb_arbiter.
//   master : the surroundings (CPU bus decode, scanout, RAM), drives the inputs
//   slave  : the arbiter itself
//   CPU      : cpu_we, cpu_addr[23:0], cpu_data -> ; <- cpu_stall
//   scanout  : scan_req, scan_x[9:0], scan_y[9:0] -> ; <- scan_valid, scan_pix
//   timing   : vblank ->
//   RAM      : <- fb_addr[20:0], fb_we, fb_wdata ; fb_rdata ->
//   status   : <- front_buf, swap_pending
interface vga_fb_arbiter_if;
  logic        cpu_we;
  logic [23:0] cpu_addr;
  logic        cpu_data;
  logic        cpu_stall;
  logic        scan_req;
  logic [9:0]  scan_x;
  logic [9:0]  scan_y;
  logic        scan_valid;
  logic        scan_pix;
  logic        vblank;
  logic [20:0] fb_addr;
  logic        fb_we;
  logic        fb_wdata;
  logic        fb_rdata;
  logic        front_buf;
  logic        swap_pending;

  modport master (
    output cpu_we, cpu_addr, cpu_data, scan_req, scan_x, scan_y, vblank, fb_rdata,
    input  cpu_stall, scan_valid, scan_pix, fb_addr, fb_we, fb_wdata, front_buf, swap_pending
  );

  modport slave (
    input  cpu_we, cpu_addr, cpu_data, scan_req, scan_x, scan_y, vblank, fb_rdata,
    output cpu_stall, scan_valid, scan_pix, fb_addr, fb_we, fb_wdata, front_buf, swap_pending
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Shares the single-port framebuffer RAM between queued CPU pixel stores and
//   display scanout (scanout always wins), and sequences front/back swaps.
//   A store to 0xfffffc (low 24 bits) requests a swap; it executes in vblank
//   once every earlier store has reached RAM.
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous, active high
//   bus    : vga_fb_arbiter_if.slave (CPU, scanout, vblank, RAM, status)
// Parameters: FIFO_DEPTH (power of two, >= 2), H_RES, V_RES
// Build option: define VGA_FB_DOUBLE_BUF_EN for two buffers; without it the
//   design uses one buffer, fb_addr[20]/front_buf/swap_pending stay 0 and swap
//   commands are absorbed.
module vga_fb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480
) (
  input logic            clock,
  input logic            reset,
  vga_fb_arbiter_if.slave bus
);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [10:0] H_LIM     = 11'(H_RES);
  localparam logic [10:0] V_LIM     = 11'(V_RES);
  localparam logic [23:0] SWAP_ADDR = 24'hfffffc;

  logic [9:0]  st_x, st_y;
  logic        is_swap, out_of_range, pix_store, push, pop;
  logic [20:0] fifo_mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic [20:0] head;
  logic        front, pending, write_buf, stall;
  logic [20:0] addr, last_addr;
  logic        we, wdata, scan_valid_q;

  assign st_x = bus.cpu_addr[9:0];
  assign st_y = bus.cpu_addr[19:10];
  assign is_swap = (bus.cpu_addr == SWAP_ADDR);
  // The swap address decodes as an off-screen pixel; classify it as a swap first.
  assign out_of_range = ~is_swap & (({1'b0, st_x} >= H_LIM) | ({1'b0, st_y} >= V_LIM));
  assign pix_store = bus.cpu_we & ~is_swap & ~out_of_range;

  // Extra pointer bit distinguishes full from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head = fifo_mem[rd_ptr[PW-1:0]];

`ifdef VGA_FB_DOUBLE_BUF_EN
  logic swap_go;

  // Stall sees pre-pop occupancy, so a full FIFO never bypasses. Dropped
  // stores never stall; everything after a swap waits for it to execute.
  assign stall   = bus.cpu_we & ~out_of_range & (fifo_full | pending);
  assign swap_go = pending & bus.vblank & fifo_empty & ~we;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      front   <= 1'b0;
      pending <= 1'b0;
    end else if (swap_go) begin
      front   <= ~front;
      pending <= 1'b0;
    end else if (bus.cpu_we & is_swap & ~stall) begin
      pending <= 1'b1;
    end
  end

  assign write_buf = ~front;
`else
  logic unused_vblank;

  assign unused_vblank = bus.vblank;
  assign stall     = pix_store & fifo_full;
  assign front     = 1'b0;
  assign pending   = 1'b0;
  assign write_buf = 1'b0;
`endif

  assign push = pix_store & ~stall;

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= {st_y, st_x, bus.cpu_data};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // RAM port: scanout first, then FIFO drain, otherwise hold the address.
  always_comb begin
    pop   = 1'b0;
    we    = 1'b0;
    wdata = 1'b0;
    addr  = last_addr;
    if (bus.scan_req) begin
      addr = {front, bus.scan_y, bus.scan_x};
    end else if (!fifo_empty) begin
      pop   = 1'b1;
      we    = 1'b1;
      addr  = {write_buf, head[20:1]};
      wdata = head[0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_addr    <= '0;
      scan_valid_q <= 1'b0;
    end else begin
      if (bus.scan_req | pop) last_addr <= addr;
      scan_valid_q <= bus.scan_req;
    end
  end

  assign bus.cpu_stall    = stall;
  assign bus.fb_addr      = addr;
  assign bus.fb_we        = we;
  assign bus.fb_wdata     = wdata;
  assign bus.scan_valid   = scan_valid_q;
  assign bus.scan_pix     = scan_valid_q & bus.fb_rdata;
  assign bus.front_buf    = front;
  assign bus.swap_pending = pending;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter
//   Directed stimulus for vga_fb_arbiter with a queue-based reference model
//   checked every cycle, plus literal expectations at key points.
//   Honours VGA_FB_DOUBLE_BUF_EN the same way as the design.
module tb_vga_fb_arbiter;
  localparam int DEPTH = 4;
`ifdef VGA_FB_DOUBLE_BUF_EN
  localparam logic DBL = 1'b1;
`else
  localparam logic DBL = 1'b0;
`endif

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       d;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  vga_fb_arbiter_if bus ();

  vga_fb_arbiter #(.FIFO_DEPTH(DEPTH), .H_RES(640), .V_RES(480)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Physical RAM behind the DUT: synchronous read, one-cycle latency.
  logic ram [int];
  logic [20:0] r_addr;
  logic        r_we, r_wdata;

  function automatic logic ram_rd(input int a);
    return ram.exists(a) ? ram[a] : 1'b0;
  endfunction

  always @(negedge clock) begin
    r_addr  = bus.fb_addr;
    r_we    = bus.fb_we;
    r_wdata = bus.fb_wdata;
  end

  always @(posedge clock) begin
    bus.fb_rdata <= ram_rd(int'(r_addr));
    if (r_we === 1'b1) ram[int'(r_addr)] = r_wdata;
  end

  // Reference model: pending writes as a queue, framebuffer as a sparse array.
  logic mdl_mem [int];
  wr_t  m_q [$];
  logic m_front, m_pend, m_prev_req, m_prev_pix;
  logic m_swap, m_oor, m_full, m_empty, m_stall, m_we, m_bufw;
  wr_t  m_e;

  function automatic logic mdl_rd(input int a);
    return mdl_mem.exists(a) ? mdl_mem[a] : 1'b0;
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      m_q.delete();
      m_front    = 1'b0;
      m_pend     = 1'b0;
      m_prev_req = 1'b0;
      m_prev_pix = 1'b0;
    end else begin
      m_swap  = bus.cpu_we && (bus.cpu_addr == 24'hfffffc);
      m_oor   = !m_swap && (bus.cpu_addr[9:0] >= 10'd640 || bus.cpu_addr[19:10] >= 10'd480);
      m_full  = (m_q.size() >= DEPTH);
      m_empty = (m_q.size() == 0);
      m_stall = DBL ? (bus.cpu_we && !m_oor && (m_full || m_pend))
                    : (bus.cpu_we && !m_swap && !m_oor && m_full);
      m_we    = !bus.scan_req && !m_empty;
      m_bufw  = DBL & ~m_front;

      check("cpu_stall", bus.cpu_stall, m_stall);
      check("fb_we", bus.fb_we, m_we);
      check("scan_valid", bus.scan_valid, m_prev_req);
      check("scan_pix", bus.scan_pix, m_prev_req & m_prev_pix);
      check("front_buf", bus.front_buf, m_front);
      check("swap_pending", bus.swap_pending, m_pend);

      m_prev_req = bus.scan_req;
      if (bus.scan_req) begin
        check("fb_addr_scan", bus.fb_addr, {m_front, bus.scan_y, bus.scan_x});
        m_prev_pix = mdl_rd(int'({m_front, bus.scan_y, bus.scan_x}));
      end else if (m_we) begin
        m_e = m_q.pop_front();
        check("fb_addr_write", bus.fb_addr, {m_bufw, m_e.y, m_e.x});
        check("fb_wdata", bus.fb_wdata, m_e.d);
        mdl_mem[int'({m_bufw, m_e.y, m_e.x})] = m_e.d;
      end

      if (bus.cpu_we && !m_stall && !m_swap && !m_oor)
        m_q.push_back('{x: bus.cpu_addr[9:0], y: bus.cpu_addr[19:10], d: bus.cpu_data});

      if (m_pend && bus.vblank && m_empty) begin
        m_front = ~m_front;
        m_pend  = 1'b0;
      end else if (DBL && m_swap && !m_stall) begin
        m_pend = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic store(input logic [9:0] x, input logic [9:0] y, input logic d);
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = {4'h0, y, x};
    bus.cpu_data = d;
  endtask

  logic [7:0]  pat;
  logic [20:0] ea;
  int          seen;

  initial begin
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_data = 1'b0;
    bus.scan_req = 1'b0;
    bus.scan_x   = '0;
    bus.scan_y   = '0;
    bus.vblank   = 1'b0;
    bus.fb_rdata = 1'b0;
    pat = 8'hA5;

    // Reset, then idle outputs.
    repeat (2) step();
    @(negedge clock);
    check("rst_stall", bus.cpu_stall, 1'b0);
    check("rst_fb_we", bus.fb_we, 1'b0);
    check("rst_scan_valid", bus.scan_valid, 1'b0);
    check("rst_front", bus.front_buf, 1'b0);
    check("rst_pending", bus.swap_pending, 1'b0);
    step();
    reset = 1'b0;
    step();

    // Single store x=3, y=2.
    store(10'd3, 10'd2, 1'b1);
    @(negedge clock);
    check("st1_stall", bus.cpu_stall, 1'b0);
    step();
    bus.cpu_we = 1'b0;
    @(negedge clock);
    check("st1_fb_we", bus.fb_we, 1'b1);
    ea = {DBL, 10'd2, 10'd3};
    check("st1_fb_addr", bus.fb_addr, ea);
    check("st1_wdata", bus.fb_wdata, 1'b1);
    step();

    // x=640 is dropped.
    store(10'd640, 10'd5, 1'b1);
    @(negedge clock);
    check("oor_stall", bus.cpu_stall, 1'b0);
    step();
    bus.cpu_we = 1'b0;
    @(negedge clock);
    check("oor_fb_we", bus.fb_we, 1'b0);
    step();

    // Five stores under continuous scanout.
    bus.scan_req = 1'b1;
    bus.scan_x   = 10'd100;
    bus.scan_y   = 10'd7;
    for (int i = 0; i < 4; i++) begin
      store(10'(20 + i), 10'(10 + i), i[0]);
      step();
    end
    store(10'd24, 10'd14, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("full_stall", bus.cpu_stall, 1'b1);
      check("full_no_we", bus.fb_we, 1'b0);
      step();
    end
    bus.scan_req = 1'b0;
    @(negedge clock);
    check("release_stall", bus.cpu_stall, 1'b1);
    ea = {DBL, 10'd10, 10'd20};
    check("release_first_addr", bus.fb_addr, ea);
    step();
    @(negedge clock);
    check("store5_accept", bus.cpu_stall, 1'b0);
    step();
    bus.cpu_we = 1'b0;
    repeat (6) step();

    // Scanout of 0xA5 on row 5.
    for (int i = 0; i < 8; i++) begin
      ram[int'({1'b0, 10'd5, 10'(i)})]     = pat[7 - i];
      mdl_mem[int'({1'b0, 10'd5, 10'(i)})] = pat[7 - i];
    end
    bus.scan_req = 1'b1;
    bus.scan_x   = 10'd0;
    bus.scan_y   = 10'd5;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i < 8) bus.scan_x = 10'(i);
      else       bus.scan_req = 1'b0;
      @(negedge clock);
      check("scan_valid_lit", bus.scan_valid, 1'b1);
      check("scan_pix_lit", bus.scan_pix, pat[8 - i]);
    end
    step();
    @(negedge clock);
    check("scan_valid_end", bus.scan_valid, 1'b0);
    step();

    // Swap with two stores queued, vblank low.
    bus.scan_req = 1'b1;
    store(10'd1, 10'd1, 1'b1);
    step();
    store(10'd2, 10'd1, 1'b1);
    step();
    bus.cpu_addr = 24'hfffffc;
    bus.cpu_data = 1'b0;
    @(negedge clock);
    check("swap_cmd_stall", bus.cpu_stall, 1'b0);
    step();
    bus.scan_req = 1'b0;
    store(10'd3, 10'd1, 1'b1);
    @(negedge clock);
    check("swap_pending_set", bus.swap_pending, DBL);
    check("post_swap_stall", bus.cpu_stall, DBL);
    repeat (3) step();
    bus.vblank = 1'b1;
    @(negedge clock);
    check("pre_swap_front", bus.front_buf, 1'b0);
    step();
    bus.vblank = 1'b0;
    @(negedge clock);
    check("post_swap_front", bus.front_buf, DBL);
    check("post_swap_pending", bus.swap_pending, 1'b0);
    step();
    bus.cpu_we = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      @(negedge clock);
      if (bus.fb_we === 1'b1 && bus.fb_addr[19:0] === {10'd1, 10'd3}) begin
        seen = 1;
        check("stalled_store_buf", bus.fb_addr[20], 1'b0);
      end
      step();
    end
    check("stalled_store_seen", seen, 1);
    repeat (3) step();

    // Reset in the middle of a drain with a swap pending.
    bus.scan_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      store(10'(30 + i), 10'd2, 1'b1);
      step();
    end
    bus.cpu_addr = 24'hfffffc;
    step();
    bus.cpu_we   = 1'b0;
    bus.scan_req = 1'b0;
    @(negedge clock);
    check("drain_running", bus.fb_we, 1'b1);
    step();
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_front", bus.front_buf, 1'b0);
    check("async_rst_pending", bus.swap_pending, 1'b0);
    check("async_rst_fb_we", bus.fb_we, 1'b0);
    step();
    step();
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (bus.fb_we === 1'b1) seen++;
      step();
    end
    check("no_we_after_reset", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
